// File: rtl/hist_threshold_select.sv
// Captures one histogram readout into a local buffer. It then scans from the hottest bin down
// until the cumulative count reaches target_k, and reports that bin as the hot-page threshold.
module hist_threshold_select #(
  parameter int N_BINS     = 64,
  parameter int COUNT_BITS = 32,
  parameter int VALUE_BITS = 16,
  parameter int ACC_BITS   = 40,
  parameter int TIMEOUT    = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [COUNT_BITS-1:0] target_k_i,
  output logic                  rd_out_en_o,
  input  logic [COUNT_BITS-1:0] hist_data_i,
  input  logic                  hist_valid_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  found_o,
  output logic                  timeout_o,
  output logic [5:0]            thresh_bin_o,
  output logic [VALUE_BITS-1:0] thresh_value_o,
  output logic [ACC_BITS-1:0]   cum_count_o,
  output logic [ACC_BITS-1:0]   total_count_o
);
  localparam int IDX_W = 6;
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_BIN = IDX_W'(N_BINS - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, REQ, CAPTURE, SCAN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [COUNT_BITS-1:0]   bin_buf [N_BINS];
  logic [COUNT_BITS-1:0]   target_q;
  logic [IDX_W-1:0]        beat_idx_q, scan_idx_q, bin_q;
  logic [TO_W-1:0]         idle_cnt_q;
  logic [ACC_BITS-1:0]     cum_q, total_q, cum_next;
  logic                    found_q, timeout_q, hit;

  // Log-bucket lower bound: group g spans 8 bins of width 2^g starting at 8*(2^g-1).
  function automatic logic [VALUE_BITS-1:0] bin_to_value(input logic [5:0] bin);
    logic [31:0] base, off;
    base = ((32'd1 << bin[5:3]) - 32'd1) << 3;
    off  = 32'(bin[2:0]) << bin[5:3];
    return VALUE_BITS'(base + off);
  endfunction

  assign cum_next = cum_q + ACC_BITS'(bin_buf[scan_idx_q]);
  assign hit      = (cum_next >= ACC_BITS'(target_q));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    rd_out_en_o = 1'b0;
    busy_o      = (state_q != IDLE);
    done_o      = 1'b0;
    case (state_q)
      IDLE:    if (start_i) state_d = REQ;
      REQ: begin
        rd_out_en_o = 1'b1;
        state_d     = CAPTURE;
      end
      CAPTURE: begin
        if (hist_valid_i && beat_idx_q == LAST_BIN)       state_d = SCAN;
        else if (!hist_valid_i && idle_cnt_q == TO_LAST)  state_d = DONE;
      end
      SCAN:    if (hit || scan_idx_q == '0) state_d = DONE;
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bin storage carries no reset; contents are only read after a full capture.
  always_ff @(posedge clk) begin
    if (state_q == CAPTURE && hist_valid_i) bin_buf[beat_idx_q] <= hist_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_idx_q <= '0;
      idle_cnt_q <= '0;
      scan_idx_q <= '0;
      cum_q      <= '0;
      total_q    <= '0;
      found_q    <= 1'b0;
      timeout_q  <= 1'b0;
      bin_q      <= '0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          target_q   <= target_k_i;
          beat_idx_q <= '0;
          idle_cnt_q <= '0;
          scan_idx_q <= LAST_BIN;
          cum_q      <= '0;
          total_q    <= '0;
          found_q    <= 1'b0;
          timeout_q  <= 1'b0;
          bin_q      <= '0;
        end
        CAPTURE: begin
          if (hist_valid_i) begin
            total_q    <= total_q + ACC_BITS'(hist_data_i);
            beat_idx_q <= beat_idx_q + IDX_W'(1);
            idle_cnt_q <= '0;
          end else begin
            idle_cnt_q <= idle_cnt_q + TO_W'(1);
            if (idle_cnt_q == TO_LAST) begin
              timeout_q <= 1'b1;
              found_q   <= 1'b0;
              bin_q     <= '0;
              cum_q     <= '0;
            end
          end
        end
        SCAN: begin
          cum_q      <= cum_next;
          scan_idx_q <= scan_idx_q - IDX_W'(1);
          if (hit) begin
            found_q <= 1'b1;
            bin_q   <= scan_idx_q;
          end else if (scan_idx_q == '0) begin
            bin_q   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign found_o        = found_q;
  assign timeout_o      = timeout_q;
  assign thresh_bin_o   = bin_q;
  assign thresh_value_o = bin_to_value(bin_q);
  assign cum_count_o    = cum_q;
  assign total_count_o  = total_q;
endmodule

// File: tb/tb_hist_threshold_select.sv
// Randomized scoreboard bench for hist_threshold_select: expected results are queued at start
// and popped by a monitor on every done_o pulse.
module tb_hist_threshold_select;
  localparam int N  = 64;
  localparam int TO = 256;

  logic        clk = 1'b0;
  logic        rst, start_i, hist_valid_i;
  logic [31:0] target_k_i, hist_data_i;
  logic        rd_out_en_o, busy_o, done_o, found_o, timeout_o;
  logic [5:0]  thresh_bin_o;
  logic [15:0] thresh_value_o;
  logic [39:0] cum_count_o, total_count_o;

  hist_threshold_select dut (
    .clk(clk), .rst(rst), .start_i(start_i), .target_k_i(target_k_i),
    .rd_out_en_o(rd_out_en_o), .hist_data_i(hist_data_i), .hist_valid_i(hist_valid_i),
    .busy_o(busy_o), .done_o(done_o), .found_o(found_o), .timeout_o(timeout_o),
    .thresh_bin_o(thresh_bin_o), .thresh_value_o(thresh_value_o),
    .cum_count_o(cum_count_o), .total_count_o(total_count_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        found;
    logic        tout;
    logic [5:0]  bin;
    logic [15:0] value;
    logic [39:0] cum;
    logic [39:0] total;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          rd_pulses = 0;
  logic [31:0] d[N];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  function automatic int bin_value(input int b);
    int g, o;
    g = b / 8;
    o = b % 8;
    return 8 * (2 ** g - 1) + o * (2 ** g);
  endfunction

  // Reference: sum everything, then walk bins from the top until the running sum meets target.
  function automatic exp_t model(input logic [31:0] tgt, input int nbeats);
    exp_t   e;
    longint tot, cum;
    e   = '0;
    tot = 0;
    cum = 0;
    for (int i = 0; i < nbeats; i++) tot += longint'(d[i]);
    e.total = 40'(tot);
    if (nbeats < N) begin
      e.tout = 1'b1;
      return e;
    end
    for (int i = N - 1; i >= 0; i--) begin
      cum += longint'(d[i]);
      if (cum >= longint'(tgt)) begin
        e.found = 1'b1;
        e.bin   = 6'(i);
        break;
      end
    end
    e.cum   = 40'(cum);
    e.value = 16'(bin_value(int'(e.bin)));
    return e;
  endfunction

  always @(negedge clk) if (rd_out_en_o === 1'b1) rd_pulses++;

  always @(negedge clk) begin
    if (rst === 1'b0 && done_o === 1'b1) begin
      check("sb_pending", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("found", found_o, e.found);
        check("timeout", timeout_o, e.tout);
        check("bin", thresh_bin_o, e.bin);
        check("value", thresh_value_o, e.value);
        check("cum", cum_count_o, e.cum);
        check("total", total_count_o, e.total);
      end
    end
  end

  task automatic run(input logic [31:0] tgt, input int nbeats, input bit gaps, input bit poke);
    exp_t e;
    int   rp0, cnt, want_cyc;
    bit   seen;
    e = model(tgt, nbeats);
    sb.push_back(e);
    rp0 = rd_pulses;
    start_i = 1'b1;
    target_k_i = tgt;
    @(posedge clk); #1;
    start_i = 1'b0;
    target_k_i = $urandom;
    check("rd_out_en", rd_out_en_o, 1);
    check("busy_req", busy_o, 1);
    @(posedge clk); #1;
    for (int b = 0; b < nbeats; b++) begin
      if (gaps) repeat ($urandom_range(0, 3)) begin
        hist_valid_i = 1'b0;
        @(posedge clk); #1;
      end
      hist_valid_i = 1'b1;
      hist_data_i  = d[b];
      start_i      = poke && (b == 10);
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    hist_valid_i = 1'b0;
    hist_data_i  = $urandom;
    want_cyc = (nbeats < N) ? TO : (e.found ? N - int'(e.bin) : N);
    cnt  = 0;
    seen = 1'b0;
    while (!seen && cnt < 400) begin
      if (done_o === 1'b1) seen = 1'b1;
      else begin
        start_i      = poke && (cnt == 1);
        hist_valid_i = (nbeats == N) ? 1'($urandom_range(0, 1)) : 1'b0;
        @(posedge clk); #1;
        start_i = 1'b0;
        cnt++;
      end
    end
    hist_valid_i = 1'b0;
    check("done_seen", 64'(seen), 64'd1);
    check("latency", 64'(cnt), 64'(want_cyc));
    @(posedge clk); #1;
    check("busy_after", busy_o, 0);
    check("done_single", done_o, 0);
    check("found_hold", found_o, e.found);
    check("rd_pulses", 64'(rd_pulses - rp0), 64'd1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start_i = 1'b0; hist_valid_i = 1'b0; target_k_i = '0; hist_data_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_rd_en", rd_out_en_o, 0);
    check("rst_found", found_o, 0);
    check("rst_bin", thresh_bin_o, 0);
    check("rst_value", thresh_value_o, 0);
    check("rst_total", total_count_o, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (d[i]) d[i] = '0;
    d[63] = 5; d[40] = 10;
    run(32'd12, N, 1'b0, 1'b0);

    foreach (d[i]) d[i] = 32'd1;
    run(32'd100, N, 1'b1, 1'b0);

    foreach (d[i]) d[i] = $urandom;
    run(32'd0, N, 1'b1, 1'b0);

    foreach (d[i]) d[i] = $urandom_range(0, 1000);
    run(32'd500, 30, 1'b0, 1'b0);

    foreach (d[i]) d[i] = 32'd1;
    run(32'd1000, N, 1'b0, 1'b1);

    // Reset in the middle of a scan, then a clean run.
    start_i = 1'b1; target_k_i = 32'd100;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(posedge clk); #1;
    for (int b = 0; b < N; b++) begin
      hist_valid_i = 1'b1; hist_data_i = 32'd1;
      @(posedge clk); #1;
    end
    hist_valid_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid_scan_busy", busy_o, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mrst_busy", busy_o, 0);
    check("mrst_cum", cum_count_o, 0);
    check("mrst_total", total_count_o, 0);
    check("mrst_found", found_o, 0);
    @(posedge clk); #1;
    foreach (d[i]) d[i] = '0;
    d[10] = 7;
    run(32'd7, N, 1'b0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      if (r % 2 == 0) begin
        foreach (d[i]) d[i] = $urandom_range(0, 100);
        run($urandom_range(0, 7000), N, 1'(r % 3 == 0), 1'b0);
      end else begin
        foreach (d[i]) d[i] = $urandom;
        run($urandom, N, 1'b1, 1'b0);
      end
    end

    repeat (5) @(posedge clk);
    #1;
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
